alu_sched: RTL and testbench

Two-requester scheduler and sequencer for the shared 32-bit carry-lookahead ALU. It arbitrates round-robin between two valid/ready request ports and decodes a 4-bit ALU opcode into the ALU control lines (A_invert, B_invert, cin, operation, less). It runs the two-pass sequence SLT needs: a subtract to form the less bit, then the SLT pass. It returns a registered result through a valid/ready response port. It sits between the issue logic and the ALU instance; the ALU itself stays purely combinational.

---
 rtl/alu_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler and opcode sequencer in front of the shared
// combinational 32-bit ALU. Two request ports are arbitrated and the opcode is
// decoded into ALU control lines. SLT runs as two passes: a subtract to form the
// less bit, then the SLT pass. The result is returned on a registered
// valid/ready response port.
module alu_sched #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_a_invert,
  output logic              alu_b_invert,
  output logic              alu_cin,
  output logic              alu_less,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_v
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_SLT1 = 3'd2,
    S_SLT2 = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic [3:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_lt;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_id;
  logic                r_rsp_zero;
  logic                r_rsp_ovf;
  logic                r_rsp_err;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic                w_sel;
  logic [3:0]          w_op_in;
  logic [DATA_W-1:0]   w_a_in;
  logic [DATA_W-1:0]   w_b_in;
  logic                w_legal_in;
  logic                w_unused;

  // Carry out is a debug-only ALU output; it does not feed any logic here.
  assign w_unused = alu_cout;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  end

  assign req0_ready = (r_state == S_IDLE) & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & w_grant1;
  assign w_accept   = req0_ready | req1_ready;
  assign w_sel      = req1_ready;
  assign w_op_in    = w_sel ? req1_op : req0_op;
  assign w_a_in     = w_sel ? req1_a  : req0_a;
  assign w_b_in     = w_sel ? req1_b  : req0_b;
  assign w_legal_in = op_legal(w_op_in);

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: sequence single-pass, two-pass SLT and illegal requests.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal_in) begin
            w_next = S_RESP;
          end else if (w_op_in == OP_SLT) begin
            w_next = S_SLT1;
          end else begin
            w_next = S_EXEC;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC:  w_next = S_RESP;
      S_SLT1:  w_next = S_SLT2;
      S_SLT2:  w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ALU control decode; the ALU sees all-zero inputs outside the execute states.
  always_comb begin
    alu_src1      = '0;
    alu_src2      = '0;
    alu_a_invert  = 1'b0;
    alu_b_invert  = 1'b0;
    alu_cin       = 1'b0;
    alu_less      = 1'b0;
    alu_operation = 2'b00;
    case (r_state)
      S_EXEC: begin
        alu_src1 = r_a;
        alu_src2 = r_b;
        case (r_op)
          OP_AND:  alu_operation = 2'b00;
          OP_OR:   alu_operation = 2'b01;
          OP_ADD:  alu_operation = 2'b10;
          OP_SUB: begin
            alu_b_invert  = 1'b1;
            alu_cin       = 1'b1;
            alu_operation = 2'b10;
          end
          OP_NOR: begin
            alu_a_invert  = 1'b1;
            alu_b_invert  = 1'b1;
            alu_operation = 2'b00;
          end
          default: alu_operation = 2'b00;
        endcase
      end
      S_SLT1: begin
        alu_src1      = r_a;
        alu_src2      = r_b;
        alu_b_invert  = 1'b1;
        alu_cin       = 1'b1;
        alu_operation = 2'b10;
      end
      S_SLT2: begin
        alu_src1      = r_a;
        alu_src2      = r_b;
        alu_b_invert  = 1'b1;
        alu_cin       = 1'b1;
        alu_operation = 2'b11;
        alu_less      = r_lt;
      end
      default: alu_operation = 2'b00;
    endcase
  end

  // Request latch, arbitration history, less-bit capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= 4'b0000;
      r_a          <= '0;
      r_b          <= '0;
      r_lt         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op         <= w_op_in;
            r_a          <= w_a_in;
            r_b          <= w_b_in;
            r_last_grant <= w_sel;
            r_rsp_id     <= w_sel;
            r_rsp_err    <= ~w_legal_in;
            if (!w_legal_in) begin
              r_rsp_data <= '0;
              r_rsp_zero <= 1'b1;
              r_rsp_ovf  <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          r_rsp_data <= alu_result;
          r_rsp_zero <= (alu_result == '0);
          r_rsp_ovf  <= ((r_op == OP_ADD) || (r_op == OP_SUB)) & alu_v;
        end
        S_SLT1: begin
          // Sign of the difference corrected by overflow gives the true signed compare.
          r_lt <= alu_result[DATA_W-1] ^ alu_v;
        end
        S_SLT2: begin
          r_rsp_data <= alu_result;
          r_rsp_zero <= (alu_result == '0);
          r_rsp_ovf  <= 1'b0;
        end
        default: begin
          r_lt <= r_lt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized and directed bench for alu_sched with a behavioural
// ALU attached to the ALU port and a reference model of the expected responses.
module tb_alu_sched;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        alu_a_invert, alu_b_invert, alu_cin, alu_less, alu_cout, alu_v;
  logic [1:0]  alu_operation;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] bp_a, bp_b;

  alu_sched #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_a_invert(alu_a_invert), .alu_b_invert(alu_b_invert), .alu_cin(alu_cin),
    .alu_less(alu_less), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_v(alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU (invert, add with carry-in, LESS passes the less bit).
  logic [31:0] m_ax, m_bx;
  logic [32:0] m_sum;
  always_comb begin
    m_ax  = alu_a_invert ? ~alu_src1 : alu_src1;
    m_bx  = alu_b_invert ? ~alu_src2 : alu_src2;
    m_sum = {1'b0, m_ax} + {1'b0, m_bx} + {32'd0, alu_cin};
    case (alu_operation)
      2'b00:   alu_result = m_ax & m_bx;
      2'b01:   alu_result = m_ax | m_bx;
      2'b10:   alu_result = m_sum[31:0];
      default: alu_result = {31'd0, alu_less};
    endcase
    alu_cout = m_sum[32];
    alu_v    = (m_ax[31] == m_bx[31]) && (m_sum[31] != m_ax[31]);
  end

  // Reference result {data, ovf, err} straight from the opcode semantics.
  function automatic logic [33:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    case (op)
      OP_AND: return {a & b, 2'b00};
      OP_OR:  return {a | b, 2'b00};
      OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); return {r, v, 1'b0}; end
      OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); return {r, v, 1'b0}; end
      OP_SLT: return {31'd0, ($signed(a) < $signed(b)), 2'b00};
      OP_NOR: return {~(a | b), 2'b00};
      default: return {32'd0, 2'b01};
    endcase
  endfunction

  // Expected {a_inv, b_inv, cin, operation} for the first (or only) ALU pass.
  function automatic logic [4:0] exp_ctrl(input logic [3:0] op);
    case (op)
      OP_AND:  return 5'b000_00;
      OP_OR:   return 5'b000_01;
      OP_ADD:  return 5'b000_10;
      OP_SUB:  return 5'b011_10;
      OP_SLT:  return 5'b011_10;
      OP_NOR:  return 5'b110_00;
      default: return 5'b000_00;
    endcase
  endfunction

  function automatic logic [3:0] pick_op(input int i);
    case (i)
      0: return OP_AND;
      1: return OP_OR;
      2: return OP_ADD;
      3: return OP_SUB;
      4: return OP_SLT;
      5: return OP_NOR;
      6: return 4'b1111;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    logic [31:0] e;
    case ($urandom_range(0, 7))
      0: e = 32'h0000_0000;
      1: e = 32'h7FFF_FFFF;
      2: e = 32'h8000_0000;
      3: e = 32'hFFFF_FFFF;
      4: e = 32'h0000_0001;
      default: e = $urandom;
    endcase
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request on a port, check decode, latency and response fields.
  // With hold>0 the response is stalled for that many cycles while the other port requests.
  task automatic run_op(input int port, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input string name);
    logic [33:0] m;
    logic [35:0] exp_rsp, obs_rsp;
    logic [69:0] alu_obs;
    logic        elt;
    int          lat, k;
    bit          got;
    m       = ref_model(op, a, b);
    elt     = ($signed(a) < $signed(b));
    exp_rsp = {m[33:2], 1'(port), (m[33:2] == 32'd0), m[1], m[0]};
    lat     = m[0] ? 1 : ((op == OP_SLT) ? 3 : 2);
    @(negedge clk);
    rsp_ready = (hold == 0);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (w > 0) begin @(negedge clk); #1; end
      got = (port == 0) ? req0_ready : req1_ready;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s accept: ready=0 after 20 cycles, required 1", name);
      if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      return;
    end
    k = 0; got = 1'b0;
    while (k < 8 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      #1;
      alu_obs = {alu_src1, alu_src2, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less};
      if (k == 1) begin
        n_tests++;
        if (m[0]) begin
          if (alu_obs !== 70'd0) begin
            n_fail++;
            $display("FAIL %s alu_idle: got %h required 0", name, alu_obs);
          end
        end else if (alu_obs !== {a, b, exp_ctrl(op), 1'b0}) begin
          n_fail++;
          $display("FAIL %s alu_pass1: got %h required %h", name, alu_obs, {a, b, exp_ctrl(op), 1'b0});
        end
      end
      if (k == 2 && op == OP_SLT) begin
        n_tests++;
        if (alu_obs !== {a, b, 5'b011_11, elt}) begin
          n_fail++;
          $display("FAIL %s alu_pass2: got %h required %h", name, alu_obs, {a, b, 5'b011_11, elt});
        end
      end
      got = rsp_valid;
    end
    n_tests++;
    if (!got || k != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (valid=%0d) required %0d", name, k, got, lat);
      if (!got) return;
    end
    obs_rsp = {rsp_data, rsp_id, rsp_zero, rsp_ovf, rsp_err};
    n_tests++;
    if (obs_rsp !== exp_rsp) begin
      n_fail++;
      $display("FAIL %s response: got %h required %h", name, obs_rsp, exp_rsp);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        if (port == 0) begin
          req1_valid = 1'b1; req1_op = OP_ADD; req1_a = bp_a; req1_b = bp_b;
        end else begin
          req0_valid = 1'b1; req0_op = OP_ADD; req0_a = bp_a; req0_b = bp_b;
        end
      end
      @(negedge clk); #1;
      obs_rsp = {rsp_data, rsp_id, rsp_zero, rsp_ovf, rsp_err};
      n_tests++;
      if (!rsp_valid || obs_rsp !== exp_rsp || req0_ready || req1_ready) begin
        n_fail++;
        $display("FAIL %s stall: valid=%0d rsp=%h rdy=%0d%0d required valid=1 rsp=%h rdy=00",
                 name, rsp_valid, obs_rsp, req0_ready, req1_ready, exp_rsp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rsp_release: valid=%0d required 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = 4'b0000; req1_op = 4'b0000;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_ovf, rsp_err} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_ovf, rsp_err});
    end
    n_tests++;
    if ({req0_ready, req1_ready, alu_src1, alu_src2, alu_a_invert, alu_b_invert, alu_cin, alu_less, alu_operation} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_alu_ready: got nonzero alu/ready outputs, required 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_ovf();
    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
  endtask

  task automatic test_sub_zero();
    run_op(1, OP_SUB, 32'd5, 32'd5, 0, "sub_zero");
  endtask

  task automatic test_slt();
    run_op(0, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0, "slt_neg");
    run_op(1, OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, "slt_ovf");
  endtask

  task automatic test_illegal();
    run_op(1, 4'b1111, $urandom, $urandom, 0, "illegal");
  endtask

  task automatic test_backpressure();
    bp_a = $urandom; bp_b = $urandom;
    run_op(0, OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5, "nor_stall");
    run_op(1, OP_ADD, bp_a, bp_b, 0, "held_req");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(0, 1)), pick_op(int'($urandom_range(0, 7))), pick_val(), pick_val(), 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  q0o[$], q1o[$];
    logic [31:0] q0a[$], q0b[$], q1a[$], q1b[$];
    logic [35:0] eq[$];
    logic [35:0] obs, ex;
    logic [33:0] m;
    int          exp_grant, n_rsp;
    bit          g0, g1, p0, p1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      q0o.push_back(pick_op(int'($urandom_range(0, 5)))); q0a.push_back(pick_val()); q0b.push_back(pick_val());
      q1o.push_back(pick_op(int'($urandom_range(0, 5)))); q1a.push_back(pick_val()); q1b.push_back(pick_val());
    end
    exp_grant = 0; n_rsp = 0; p0 = 1'b0; p1 = 1'b0;
    for (int cyc = 0; cyc < 100 && n_rsp < 8; cyc++) begin
      @(negedge clk);
      if (p0) begin void'(q0o.pop_front()); void'(q0a.pop_front()); void'(q0b.pop_front()); end
      if (p1) begin void'(q1o.pop_front()); void'(q1a.pop_front()); void'(q1b.pop_front()); end
      p0 = 1'b0; p1 = 1'b0;
      rsp_ready  = 1'b1;
      req0_valid = (q0o.size() > 0);
      if (req0_valid) begin req0_op = q0o[0]; req0_a = q0a[0]; req0_b = q0b[0]; end
      req1_valid = (q1o.size() > 0);
      if (req1_valid) begin req1_op = q1o[0]; req1_a = q1a[0]; req1_b = q1b[0]; end
      #1;
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      if (g0 || g1) begin
        n_tests++;
        if ((g0 && g1) || (int'(g1) != exp_grant)) begin
          n_fail++;
          $display("FAIL b2b_grant: got g0=%0d g1=%0d required port %0d", g0, g1, exp_grant);
        end
        if (g1) begin
          m = ref_model(q1o[0], q1a[0], q1b[0]);
          eq.push_back({m[33:2], 1'b1, (m[33:2] == 32'd0), m[1], m[0]});
          p1 = 1'b1;
        end else begin
          m = ref_model(q0o[0], q0a[0], q0b[0]);
          eq.push_back({m[33:2], 1'b0, (m[33:2] == 32'd0), m[1], m[0]});
          p0 = 1'b1;
        end
        exp_grant = 1 - exp_grant;
      end
      if (rsp_valid) begin
        obs = {rsp_data, rsp_id, rsp_zero, rsp_ovf, rsp_err};
        n_tests++;
        n_rsp++;
        if (eq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_rsp: got %h required none", obs);
        end else begin
          ex = eq.pop_front();
          if (obs !== ex) begin
            n_fail++;
            $display("FAIL b2b_rsp: got %h required %h", obs, ex);
          end
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++;
    if (n_rsp != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses required 8", n_rsp);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SLT; req0_a = $urandom; req0_b = $urandom;
    #1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (w > 0) begin @(negedge clk); #1; end
      got = req0_ready;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL rstmid_accept: ready=0 required 1");
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (alu_operation !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_slt2: alu_operation=%b required 11", alu_operation);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, req0_ready, req1_ready, alu_src1, alu_src2, alu_a_invert, alu_b_invert, alu_cin, alu_less, alu_operation} !== 73'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: outputs not at reset values, valid=%0d op=%b", rsp_valid, alu_operation);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_rsp: rsp_valid=%0d required 0", rsp_valid);
      end
    end
    run_op(0, OP_ADD, $urandom, $urandom, 0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_slt();
    test_illegal();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
